// File: rtl/sva_pkg.sv
// Shared types and constants for the SVA checker stimulus generator.
package sva_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    RUN,
    DRAIN
  } stim_state_t;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, output taken from bit 0
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // An all-zero seed would lock the LFSR, so substitute the default
  function automatic logic [15:0] lfsr_seed(input logic [15:0] raw);
    return (raw == '0) ? LFSR_DEFAULT_SEED : raw;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sva_clk_div.sv
// User-clock divider: gclk toggles every DIV_HALF enabled sys_clk cycles.
// rise/fall are combinational strobes marking the edge at which gclk changes.
module sva_clk_div #(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gclk_q, gclk_d;
  logic          wrap;

  // Half-period counting; disabled divider sits at count 0 with gclk low
  always_comb begin
    wrap   = (cnt_q == CW'(DIV_HALF - 1));
    cnt_d  = cnt_q;
    gclk_d = gclk_q;
    if (!en) begin
      cnt_d  = '0;
      gclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      gclk_d = ~gclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
    rise = en && wrap && !gclk_q;
    fall = en && wrap && gclk_q;
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      gclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gclk_q <= gclk_d;
    end
  end

  assign gclk = gclk_q;

endmodule

// File: rtl/sva_stim_gen.sv
// Stimulus driver for SVA checker FSMs: generates gclk/grst, serialises a
// pattern onto b on gclk falls, and counts succ/fail/lazy_succ rising edges.
// Optional LFSR bit source is compiled in with `define SVA_STIM_LFSR_EN.
module sva_stim_gen
  import sva_pkg::*;
#(
  parameter int unsigned DIV_HALF     = 2,
  parameter int unsigned PAT_WIDTH    = 32,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           start,
  input  logic                           pat_load,
  input  logic [PAT_WIDTH-1:0]           pat_data,
  input  logic [$clog2(PAT_WIDTH+1)-1:0] pat_len,
  input  logic                           loop_en,
  input  logic                           lfsr_mode,
  input  logic                           succ,
  input  logic                           fail,
  input  logic                           lazy_succ,
  output logic                           gclk,
  output logic                           grst,
  output logic                           b,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_WIDTH-1:0]           succ_cnt,
  output logic [CNT_WIDTH-1:0]           fail_cnt,
  output logic [CNT_WIDTH-1:0]           lazy_cnt
);

  localparam int unsigned LEN_W   = $clog2(PAT_WIDTH + 1);
  localparam int unsigned PER_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PER_W   = $clog2(PER_MAX + 1);

  stim_state_t          state_q, state_d;
  logic                 grst_q, grst_d;
  logic                 b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [PER_W-1:0]     per_q, per_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [PAT_WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [PAT_WIDTH-1:0] sh_q, sh_d;

  logic                 start_go, load_go;
  logic [PAT_WIDTH-1:0] pat_next;
  logic [LEN_W-1:0]     len_next;
  logic                 src_load, src_adv, src_restart;
  logic                 src_bit, restart_bit;
  logic                 gclk_en, gclk_fall, unused_gclk_rise;

  assign gclk_en = (state_q != IDLE);

  sva_clk_div #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_div (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .en   (gclk_en),
    .gclk (gclk),
    .rise (unused_gclk_rise),
    .fall (gclk_fall)
  );

  // Run sequencing; b and grst only move on the cycle gclk falls.
  // idx counts bits already presented, so idx==len marks the end of the last bit's period.
  always_comb begin
    start_go    = start && (state_q == IDLE);
    load_go     = pat_load && (state_q == IDLE);
    pat_next    = load_go ? pat_data : pat_q;
    len_next    = load_go ? ((pat_len > LEN_W'(PAT_WIDTH)) ? LEN_W'(PAT_WIDTH) : pat_len) : len_q;
    state_d     = state_q;
    grst_d      = grst_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    per_d       = per_q;
    idx_d       = idx_q;
    pat_d       = pat_next;
    len_d       = len_next;
    src_load    = 1'b0;
    src_adv     = 1'b0;
    src_restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        grst_d = 1'b1;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start_go) begin
          state_d  = RST;
          busy_d   = 1'b1;
          per_d    = '0;
          idx_d    = '0;
          src_load = 1'b1;
        end
      end
      RST: begin
        if (gclk_fall) begin
          if (per_q == PER_W'(RST_CYCLES - 1)) begin
            grst_d = 1'b0;
            per_d  = '0;
            if (len_q == '0) begin
              state_d = DRAIN;
              b_d     = 1'b0;
            end else begin
              state_d = RUN;
              b_d     = src_bit;
              src_adv = 1'b1;
              idx_d   = LEN_W'(1);
            end
          end else begin
            per_d = per_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (gclk_fall) begin
          if (idx_q == len_q) begin
            if (loop_en) begin
              b_d         = restart_bit;
              src_restart = 1'b1;
              idx_d       = LEN_W'(1);
            end else begin
              state_d = DRAIN;
              b_d     = 1'b0;
              per_d   = '0;
            end
          end else begin
            b_d     = src_bit;
            src_adv = 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (gclk_fall) begin
          if (per_q == PER_W'(DRAIN_CYCLES - 1)) begin
            state_d = IDLE;
            grst_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            per_d   = '0;
          end else begin
            per_d = per_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grst_q  <= 1'b1;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      per_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grst_q  <= grst_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
    end
  end

  // Pattern shifter: bit 0 is always the next bit to present
  always_comb begin
    sh_d = sh_q;
    if (src_load)         sh_d = pat_next;
    else if (src_restart) sh_d = pat_q >> 1;
    else if (src_adv)     sh_d = sh_q >> 1;
  end

  // Pattern shifter register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) sh_q <= '0;
    else         sh_q <= sh_d;
  end

`ifdef SVA_STIM_LFSR_EN
  logic        lfsr_sel_q, lfsr_sel_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] restart_seed;

  // LFSR source: mode latched at start, stepped once per presented bit
  always_comb begin
    restart_seed = lfsr_seed(16'(pat_q));
    lfsr_sel_d   = lfsr_sel_q;
    lfsr_d       = lfsr_q;
    if (src_load) begin
      lfsr_sel_d = lfsr_mode;
      lfsr_d     = lfsr_seed(16'(pat_next));
    end else if (src_restart) begin
      lfsr_d = lfsr_step(restart_seed);
    end else if (src_adv) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
    src_bit     = lfsr_sel_q ? lfsr_q[0] : sh_q[0];
    restart_bit = lfsr_sel_q ? restart_seed[0] : pat_q[0];
  end

  // LFSR registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr_sel_q <= 1'b0;
      lfsr_q     <= '0;
    end else begin
      lfsr_sel_q <= lfsr_sel_d;
      lfsr_q     <= lfsr_d;
    end
  end
`else
  logic unused_lfsr_mode;
  assign unused_lfsr_mode = lfsr_mode;

  // Pattern register is the only bit source
  always_comb begin
    src_bit     = sh_q[0];
    restart_bit = pat_q[0];
  end
`endif

  logic [2:0]           resp_in, resp_prev_q;
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];

  // Saturating rising-edge counters for succ/fail/lazy_succ; start clears them
  always_comb begin
    resp_in = {lazy_succ, fail, succ};
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (start_go)
        cnt_d[i] = '0;
      else if (resp_in[i] && !resp_prev_q[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Counter and edge-detect registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      resp_prev_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      resp_prev_q <= resp_in;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign grst     = grst_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign succ_cnt = cnt_q[0];
  assign fail_cnt = cnt_q[1];
  assign lazy_cnt = cnt_q[2];

endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed bench for sva_stim_gen: expected b bits are queued per run and
// popped at every gclk rise after grst drops; done timing and counters checked directly.
module tb_sva_stim_gen;

  localparam int unsigned PW = 32;
  localparam int unsigned LW = 6;
  localparam int unsigned RC = 2;
  localparam int unsigned DC = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0, pat_load = 1'b0, loop_en = 1'b0, lfsr_mode = 1'b0;
  logic          succ = 1'b0, fail = 1'b0, lazy_succ = 1'b0;
  logic [PW-1:0] pat_data = '0;
  logic [LW-1:0] pat_len = '0;
  logic          gclk, grst, b, busy, done;
  logic [15:0]   succ_cnt, fail_cnt, lazy_cnt;
  logic          s_gclk, s_grst, s_b, s_busy, s_done;
  logic [3:0]    s_succ_cnt, s_fail_cnt, s_lazy_cnt;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 sys_clk = ~sys_clk;

  sva_stim_gen #(
    .DIV_HALF(2), .PAT_WIDTH(PW), .RST_CYCLES(RC), .DRAIN_CYCLES(DC), .CNT_WIDTH(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .pat_load(pat_load),
    .pat_data(pat_data), .pat_len(pat_len), .loop_en(loop_en), .lfsr_mode(lfsr_mode),
    .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .gclk(gclk), .grst(grst), .b(b), .busy(busy), .done(done),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt)
  );

  sva_stim_gen #(
    .DIV_HALF(2), .PAT_WIDTH(PW), .RST_CYCLES(RC), .DRAIN_CYCLES(DC), .CNT_WIDTH(4)
  ) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .pat_load(pat_load),
    .pat_data(pat_data), .pat_len(pat_len), .loop_en(loop_en), .lfsr_mode(lfsr_mode),
    .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .gclk(s_gclk), .grst(s_grst), .b(s_b), .busy(s_busy), .done(s_done),
    .succ_cnt(s_succ_cnt), .fail_cnt(s_fail_cnt), .lazy_cnt(s_lazy_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: at each gclk rise check grst phase and pop expected b
  logic gclk_prev = 1'b0;
  int   rise_no   = 0;
  always @(negedge sys_clk) begin
    if (!busy) begin
      rise_no = 0;
    end else if (gclk && !gclk_prev) begin
      rise_no = rise_no + 1;
      chk("grst_at_rise", 32'(grst), 32'(rise_no <= RC));
      if (!grst) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL b_queue observed=empty expected=entry rise=%0d", rise_no);
        end
        if (exp_q.size() != 0) chk("b_bit", 32'(b), 32'(exp_q.pop_front()));
      end
    end
    gclk_prev = gclk;
  end

  task automatic push_pat(input logic [31:0] d, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(d[i]);
    for (int i = 0; i < DC; i++) exp_q.push_back(1'b0);
  endtask

  task automatic load(input logic [31:0] d, input logic [LW-1:0] l);
    @(negedge sys_clk);
    pat_data = d; pat_len = l; pat_load = 1'b1;
    @(negedge sys_clk);
    pat_load = 1'b0;
  endtask

  // start sampled at end of cycle 0; returns the cycle in which done is seen
  task automatic run(input int clr_loop_at, input int guard_at, output int done_cyc);
    int n;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0; n = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("succ_cnt_cleared", 32'(succ_cnt), 32'd0);
    while (!done && n < 400) begin
      @(negedge sys_clk); n++;
      if (n == clr_loop_at) loop_en = 1'b0;
      if (n == guard_at) begin
        start = 1'b1; pat_load = 1'b1; pat_data = '1; pat_len = LW'(4);
      end else if (n == guard_at + 1) begin
        start = 1'b0; pat_load = 1'b0;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    done_cyc = n;
    @(negedge sys_clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_grst", 32'(grst), 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int dcyc;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_gclk", 32'(gclk), 32'd0);
    chk("rst_grst", 32'(grst), 32'd1);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_succ_cnt", 32'(succ_cnt), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);

    // Counting and saturation
    repeat (2) begin
      @(negedge sys_clk); succ = 1'b1;
      repeat (3) @(negedge sys_clk);
      succ = 1'b0;
    end
    repeat (20) begin
      @(negedge sys_clk); fail = 1'b1;
      @(negedge sys_clk); fail = 1'b0;
    end
    @(negedge sys_clk); lazy_succ = 1'b1;
    repeat (5) @(negedge sys_clk);
    lazy_succ = 1'b0;
    @(negedge sys_clk);
    chk("succ_cnt_two_pulses", 32'(succ_cnt), 32'd2);
    chk("fail_cnt_20", 32'(fail_cnt), 32'd20);
    chk("lazy_cnt_level_once", 32'(lazy_cnt), 32'd1);
    chk("sat_fail_cnt", 32'(s_fail_cnt), 32'd15);
    chk("sat_succ_cnt", 32'(s_succ_cnt), 32'd2);

    // Basic pattern
    load(32'h3, LW'(4));
    push_pat(32'h3, 4);
    run(0, 0, dcyc);
    chk("done_cycle_basic", dcyc, 32'd41);

    // Zero length: pattern bits must not appear
    load(32'hF, LW'(0));
    push_pat(32'h0, 0);
    run(0, 0, dcyc);
    chk("done_cycle_zero_len", dcyc, 32'd25);

    // start/pat_load during RUN ignored, then rerun with retained pattern
    load(32'h5, LW'(4));
    push_pat(32'h5, 4);
    run(0, 14, dcyc);
    chk("done_cycle_guard", dcyc, 32'd41);
    push_pat(32'h5, 4);
    run(0, 0, dcyc);
    chk("done_cycle_retained", dcyc, 32'd41);

    // Length above PAT_WIDTH clamps
    load(32'hF0F0_1234, LW'(40));
    push_pat(32'hF0F0_1234, 32);
    run(0, 0, dcyc);
    chk("done_cycle_clamp", dcyc, 32'd153);

    // Looping: three passes of 1,0 then loop_en cleared before the next end
    load(32'h1, LW'(2));
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin exp_q.push_back(1'b1); exp_q.push_back(1'b0); end
    for (int i = 0; i < DC; i++) exp_q.push_back(1'b0);
    run(30, 0, dcyc);
    chk("done_cycle_loop", dcyc, 32'd49);

    // sys_rst in the middle of RUN
    load(32'h3, LW'(4));
    push_pat(32'h3, 4);
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    for (int n = 2; n <= 15; n++) begin
      @(negedge sys_clk);
      if (n == 5) succ = 1'b1;
      if (n == 6) succ = 1'b0;
    end
    chk("pre_rst_gclk_high", 32'(gclk), 32'd1);
    chk("pre_rst_succ_cnt", 32'(succ_cnt), 32'd1);
    chk("pre_rst_b", 32'(b), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("midrst_gclk", 32'(gclk), 32'd0);
    chk("midrst_grst", 32'(grst), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_b", 32'(b), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_succ_cnt", 32'(succ_cnt), 32'd0);
    exp_q.delete();
    @(negedge sys_clk);
    chk("midrst_no_done", 32'(done), 32'd0);

`ifdef SVA_STIM_LFSR_EN
    begin
      logic [15:0] s;
      s = 16'hACE1;
      load(32'h0, LW'(8));
      lfsr_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(s[0]);
        s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
      for (int i = 0; i < DC; i++) exp_q.push_back(1'b0);
      run(0, 0, dcyc);
      chk("done_cycle_lfsr", dcyc, 32'd57);
      lfsr_mode = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
